// File: rtl/fifo_wptr_full_pkg.sv
// fifo_pkg: pointer helpers shared by the write-side and read-side FIFO blocks.
//   ptr_width(addr_width) : pointer width, one wrap bit above the RAM address
//   bin2grey / grey2bin   : Gray conversions on a 32-bit word; callers cast to
//                           their own pointer width (leading zeros are harmless
//                           in both directions)
package fifo_pkg;

  localparam int GREY_FN_WIDTH = 32;

  typedef logic [GREY_FN_WIDTH-1:0] grey_word_t;

  function automatic int ptr_width(input int addr_width);
    return addr_width + 1;
  endfunction

  function automatic grey_word_t bin2grey(input grey_word_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic grey_word_t grey2bin(input grey_word_t g);
    grey_word_t b;
    b[GREY_FN_WIDTH-1] = g[GREY_FN_WIDTH-1];
    for (int i = GREY_FN_WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_wptr_full_if.sv
// fifo_wptr_full_if: write-side FIFO bus.
//   master : write requester; drives WR_EN and the (foreign-clock) read pointer
//   slave  : fifo_wptr_full; returns RAM address, Gray pointer, ack and flags
interface fifo_wptr_full_if
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = 4
);
  localparam int PW = ptr_width(ADDR_WIDTH);

  logic                  WR_EN;
  logic [PW-1:0]         RD_PTR_GREY;
  logic [ADDR_WIDTH-1:0] WR_ADDR;
  logic [PW-1:0]         WR_PTR_GREY;
  logic                  WR_ACK;
  logic                  FULL;
  logic                  ALMOST_FULL;
  logic [PW-1:0]         WR_COUNT;
  logic                  OVERFLOW;

  modport master (
    output WR_EN, RD_PTR_GREY,
    input  WR_ADDR, WR_PTR_GREY, WR_ACK, FULL, ALMOST_FULL, WR_COUNT, OVERFLOW
  );

  modport slave (
    input  WR_EN, RD_PTR_GREY,
    output WR_ADDR, WR_PTR_GREY, WR_ACK, FULL, ALMOST_FULL, WR_COUNT, OVERFLOW
  );

endinterface

// File: rtl/fifo_wptr_full_sync_ff.sv
// sync_ff: plain flop chain for bringing a Gray pointer into CLK's domain.
//   CLK, RST_N : destination clock, async active-low reset
//   d          : asynchronous input word
//   q          : output of the last stage; no logic between stages
module sync_ff #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [STAGES];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d;
      for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/fifo_wptr_full.sv
// fifo_wptr_full: write-pointer and full-flag logic of an async FIFO.
//   CLK, RST_N : write clock, async active-low reset
//   bus        : fifo_wptr_full_if.slave
//     WR_EN in, RD_PTR_GREY in (other domain), WR_ADDR / WR_PTR_GREY out,
//     WR_ACK (combinational), FULL / ALMOST_FULL / WR_COUNT / OVERFLOW (registered)
module fifo_wptr_full
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH   = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int AFULL_THRESH = 2**ADDR_WIDTH - 2
) (
  input  logic             CLK,
  input  logic             RST_N,
  fifo_wptr_full_if.slave  bus
);

  localparam int PW = ptr_width(ADDR_WIDTH);
  // Full when the write Gray pointer equals the read Gray pointer with its top
  // two bits inverted, i.e. XOR of the two is exactly this mask.
  localparam logic [PW-1:0] FULL_MASK = PW'(3) << (ADDR_WIDTH - 1);
  localparam logic [PW-1:0] AFULL_T   = PW'(AFULL_THRESH);

  logic [PW-1:0] wbin, wbin_next, wgrey_next;
  logic [PW-1:0] rgrey_s, rbin_s, count_next;
  logic [PW-1:0] wgrey_q, count_q;
  logic          full_q, afull_q, ovf_q;
  logic          wr_ack, full_next;

  sync_ff #(
    .WIDTH  (PW),
    .STAGES (SYNC_STAGES)
  ) u_rptr_sync (
    .CLK   (CLK),
    .RST_N (RST_N),
    .d     (bus.RD_PTR_GREY),
    .q     (rgrey_s)
  );

  // RST_N term keeps the ack low while the flops are held in reset.
  assign wr_ack     = bus.WR_EN & ~full_q & RST_N;
  assign wbin_next  = wbin + PW'(wr_ack);
  assign wgrey_next = PW'(bin2grey(32'(wbin_next)));
  assign rbin_s     = PW'(grey2bin(32'(rgrey_s)));
  assign count_next = wbin_next - rbin_s;
  assign full_next  = (wgrey_next ^ rgrey_s) == FULL_MASK;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wbin    <= '0;
      wgrey_q <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      afull_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      wbin    <= wbin_next;
      wgrey_q <= wgrey_next;
      count_q <= count_next;
      full_q  <= full_next;
      // OR in full so the flag ordering holds even for thresholds above depth.
      afull_q <= full_next | (count_next >= AFULL_T);
      ovf_q   <= bus.WR_EN & full_q;
    end
  end

  assign bus.WR_ADDR     = wbin[ADDR_WIDTH-1:0];
  assign bus.WR_PTR_GREY = wgrey_q;
  assign bus.WR_ACK      = wr_ack;
  assign bus.FULL        = full_q;
  assign bus.ALMOST_FULL = afull_q;
  assign bus.WR_COUNT    = count_q;
  assign bus.OVERFLOW    = ovf_q;

endmodule

// File: tb/tb_fifo_wptr_full.sv
module tb_fifo_wptr_full;

  logic clk;
  logic rst_n;

  fifo_wptr_full_if #(.ADDR_WIDTH(2)) bus ();

  fifo_wptr_full #(
    .ADDR_WIDTH   (2),
    .SYNC_STAGES  (2),
    .AFULL_THRESH (3)
  ) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: unwrapped counts of accepted writes and reader position;
  // the read pointer reaches the flag logic two sampled edges late.
  int   m_w, m_r, rq[$];
  bit   m_full, m_afull, m_ovf, m_wen;
  int   m_count;

  function automatic logic [2:0] gray3(input int v);
    int x;
    x = v & 7;
    return 3'(x ^ (x >> 1));
  endfunction

  task automatic model_reset();
    m_w = 0; m_r = 0; rq = {0, 0};
    m_full = 0; m_afull = 0; m_ovf = 0; m_count = 0;
  endtask

  task automatic set_in(input bit wen);
    m_wen = wen;
    bus.WR_EN = wen;
    bus.RD_PTR_GREY = gray3(m_r);
  endtask

  task automatic clk_edge();
    int used, occ;
    @(posedge clk);
    used = rq.pop_front();
    rq.push_back(m_r);
    m_ovf = m_wen && m_full;
    if (m_wen && !m_full) m_w++;
    occ = m_w - used;
    m_full  = (occ == 4);
    m_afull = (occ >= 3);
    m_count = occ;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    set_in(1'b1);
    #2;
    checks++;
    if ({bus.WR_ADDR, bus.WR_PTR_GREY, bus.WR_COUNT, bus.FULL, bus.ALMOST_FULL, bus.OVERFLOW} !== '0) begin
      errors++; $display("FAIL reset_outputs got=%b exp=0",
        {bus.WR_ADDR, bus.WR_PTR_GREY, bus.WR_COUNT, bus.FULL, bus.ALMOST_FULL, bus.OVERFLOW});
    end
    checks++;
    if (bus.WR_ACK !== 1'b0) begin errors++; $display("FAIL reset_ack got=%b exp=0", bus.WR_ACK); end
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin set_in(1'b1); clk_edge(); end
    checks++;
    if (bus.WR_ADDR !== 2'd3) begin errors++; $display("FAIL prefill_addr got=%0d exp=3", bus.WR_ADDR); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.WR_ADDR, bus.WR_PTR_GREY, bus.WR_COUNT, bus.FULL, bus.ALMOST_FULL, bus.OVERFLOW} !== '0) begin
      errors++; $display("FAIL midfill_reset got=%b exp=0",
        {bus.WR_ADDR, bus.WR_PTR_GREY, bus.WR_COUNT, bus.FULL, bus.ALMOST_FULL, bus.OVERFLOW});
    end
    checks++;
    if (bus.WR_ACK !== 1'b0) begin errors++; $display("FAIL midfill_ack got=%b exp=0", bus.WR_ACK); end
    @(posedge clk); #1;
    checks++;
    if (bus.WR_PTR_GREY !== 3'b000) begin errors++; $display("FAIL held_reset_ptr got=%b exp=000", bus.WR_PTR_GREY); end
    rst_n = 1'b1;
    model_reset();
    set_in(1'b0);
    clk_edge();
  endtask

  task automatic test_fill();
    for (int k = 1; k <= 5; k++) begin
      set_in(1'b1);
      #1;
      checks++;
      if (bus.WR_ACK !== (k <= 4)) begin errors++; $display("FAIL fill_ack k=%0d got=%b exp=%b", k, bus.WR_ACK, k <= 4); end
      clk_edge();
      checks++;
      if (bus.ALMOST_FULL !== (k >= 3)) begin errors++; $display("FAIL fill_afull k=%0d got=%b exp=%b", k, bus.ALMOST_FULL, k >= 3); end
      checks++;
      if (bus.FULL !== (k >= 4)) begin errors++; $display("FAIL fill_full k=%0d got=%b exp=%b", k, bus.FULL, k >= 4); end
      checks++;
      if (bus.OVERFLOW !== (k == 5)) begin errors++; $display("FAIL fill_ovf k=%0d got=%b exp=%b", k, bus.OVERFLOW, k == 5); end
    end
    checks++;
    if (bus.WR_PTR_GREY !== 3'b110) begin errors++; $display("FAIL fill_ptr got=%b exp=110", bus.WR_PTR_GREY); end
    checks++;
    if (bus.WR_COUNT !== 3'd4) begin errors++; $display("FAIL fill_count got=%0d exp=4", bus.WR_COUNT); end
    set_in(1'b0);
    clk_edge();
    checks++;
    if (bus.OVERFLOW !== 1'b0) begin errors++; $display("FAIL ovf_single got=%b exp=0", bus.OVERFLOW); end
  endtask

  task automatic test_release();
    m_r = 1;
    for (int k = 1; k <= 3; k++) begin
      set_in(1'b0);
      clk_edge();
      checks++;
      if (bus.FULL !== (k < 3)) begin errors++; $display("FAIL release_full edge=%0d got=%b exp=%b", k, bus.FULL, k < 3); end
    end
    checks++;
    if (bus.WR_COUNT !== 3'd3) begin errors++; $display("FAIL release_count got=%0d exp=3", bus.WR_COUNT); end
  endtask

  task automatic test_boundary();
    set_in(1'b1);
    clk_edge();
    checks++;
    if (bus.FULL !== 1'b1) begin errors++; $display("FAIL bnd_refill got=%b exp=1", bus.FULL); end
    m_r = 2;
    for (int k = 1; k <= 3; k++) begin set_in(1'b1); clk_edge(); end
    checks++;
    if (bus.FULL !== 1'b0) begin errors++; $display("FAIL bnd_fall got=%b exp=0", bus.FULL); end
    checks++;
    if (bus.WR_ADDR !== 2'd1) begin errors++; $display("FAIL bnd_blocked_addr got=%0d exp=1", bus.WR_ADDR); end
    set_in(1'b1);
    #1;
    checks++;
    if (bus.WR_ACK !== 1'b1) begin errors++; $display("FAIL bnd_ack got=%b exp=1", bus.WR_ACK); end
    clk_edge();
    checks++;
    if (bus.WR_ADDR !== 2'd2) begin errors++; $display("FAIL bnd_addr got=%0d exp=2", bus.WR_ADDR); end
    checks++;
    if (bus.WR_PTR_GREY !== 3'b101) begin errors++; $display("FAIL bnd_ptr got=%b exp=101", bus.WR_PTR_GREY); end
    checks++;
    if (bus.FULL !== 1'b1) begin errors++; $display("FAIL bnd_full_again got=%b exp=1", bus.FULL); end
  endtask

  task automatic test_wrap();
    for (int k = 0; k < 30; k++) begin
      if (m_r < 4) m_r++;
      set_in(m_w < 8);
      clk_edge();
    end
    checks++;
    if (bus.WR_PTR_GREY !== 3'b000) begin errors++; $display("FAIL wrap_ptr got=%b exp=000", bus.WR_PTR_GREY); end
    checks++;
    if (bus.FULL !== 1'b1) begin errors++; $display("FAIL wrap_full got=%b exp=1", bus.FULL); end
    checks++;
    if (bus.WR_COUNT !== 3'd4) begin errors++; $display("FAIL wrap_count got=%0d exp=4", bus.WR_COUNT); end
  endtask

  task automatic test_random();
    bit wen;
    for (int k = 0; k < 400; k++) begin
      if (m_r < m_w && ($urandom % 2) == 0) m_r++;
      wen = ($urandom % 4) != 0;
      set_in(wen);
      #1;
      checks++;
      if (bus.WR_ACK !== (wen && !m_full)) begin
        errors++; $display("FAIL rnd_ack cyc=%0d got=%b exp=%b", k, bus.WR_ACK, wen && !m_full);
      end
      clk_edge();
      checks++;
      if ({bus.FULL, bus.ALMOST_FULL, bus.OVERFLOW} !== {m_full, m_afull, m_ovf}) begin
        errors++; $display("FAIL rnd_flags cyc=%0d got=%b exp=%b", k,
          {bus.FULL, bus.ALMOST_FULL, bus.OVERFLOW}, {m_full, m_afull, m_ovf});
      end
      checks++;
      if (bus.WR_COUNT !== 3'(m_count) || bus.WR_COUNT > 3'd4) begin
        errors++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", k, bus.WR_COUNT, m_count);
      end
      checks++;
      if (bus.WR_PTR_GREY !== gray3(m_w) || bus.WR_ADDR !== 2'(m_w & 3)) begin
        errors++; $display("FAIL rnd_ptr cyc=%0d got=%b/%0d exp=%b/%0d", k,
          bus.WR_PTR_GREY, bus.WR_ADDR, gray3(m_w), m_w & 3);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_release();
    test_boundary();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
